// File: rtl/reg_file_param.sv
// Parametrised register file: one write port (ALU or load source), two registered
// read ports with optional write-to-read bypass, optional hardwired-zero r0, and a
// sequenced bulk-clear engine that reports busy and a one-cycle done pulse.
module reg_file_param #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned DEPTH    = 4,
    parameter bit          ZERO_REG = 1'b0,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic             wr_sel,
    input  logic [WIDTH-1:0] alu_data,
    input  logic [WIDTH-1:0] load_data,
    input  logic [AW-1:0]    wr_addr,
    input  logic [AW-1:0]    rx_addr,
    input  logic [AW-1:0]    ry_addr,
    input  logic             clear_req,
    output logic [WIDTH-1:0] rx_out,
    output logic [WIDTH-1:0] ry_out,
    output logic             busy,
    output logic             clear_done
);

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StDone
    } state_e;

    localparam logic [AW-1:0] LastPtr = AW'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [WIDTH-1:0]  rx_q, rx_d;
    logic [WIDTH-1:0]  ry_q, ry_d;

    logic [WIDTH-1:0]  wr_data;
    logic              user_we;
    logic              clear_we;

    // Clear sequencer: walk the pointer over every entry, then announce completion.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (clear_req) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end
            end
            StClear: begin
                if (ptr_q == LastPtr) begin
                    state_d = StDone;
                    // Park the pointer so it never steps past the last entry.
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                ptr_d   = '0;
            end
        endcase
        busy_d = (state_d == StClear);
        done_d = (state_d == StDone);
    end

    // Next register contents: user write (blocked while clearing) and clear-engine write.
    always_comb begin
        wr_data  = wr_sel ? load_data : alu_data;
        user_we  = wr_en && !busy_q && !(ZERO_REG && (wr_addr == '0));
        clear_we = (state_q == StClear);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            // Addresses at or above DEPTH match no entry, so such writes are dropped.
            if (user_we && (wr_addr == AW'(i))) begin
                mem_d[i] = wr_data;
            end
            if (clear_we && (ptr_q == AW'(i))) begin
                mem_d[i] = '0;
            end
        end
    end

    // Read data for the next edge; bypass reads the post-write view of the array.
    always_comb begin
        rx_d = '0;
        ry_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rx_addr == AW'(i)) begin
                rx_d = BYPASS ? mem_d[i] : mem_q[i];
            end
            if (ry_addr == AW'(i)) begin
                ry_d = BYPASS ? mem_d[i] : mem_q[i];
            end
        end
        if (ZERO_REG && (rx_addr == '0)) begin
            rx_d = '0;
        end
        if (ZERO_REG && (ry_addr == '0)) begin
            ry_d = '0;
        end
    end

    // All state: array, read registers, sequencer and its decoded status flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rx_q    <= '0;
            ry_q    <= '0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            mem_q   <= mem_d;
        end
    end

    assign rx_out     = rx_q;
    assign ry_out     = ry_q;
    assign busy       = busy_q;
    assign clear_done = done_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: default, no-bypass and zero-register instances
// share one stimulus stream; expected values are hand-computed constants.
module tb_reg_file_param;

    logic       clock;
    logic       reset_n;
    logic       wr_en;
    logic       wr_sel;
    logic [3:0] alu_data;
    logic [3:0] load_data;
    logic [1:0] wr_addr;
    logic [1:0] rx_addr;
    logic [1:0] ry_addr;
    logic       clear_req;

    logic [3:0] rx_out, ry_out;
    logic       busy, clear_done;
    logic [3:0] nb_rx_out, nb_ry_out;
    logic       nb_busy, nb_clear_done;
    logic [3:0] z_rx_out, z_ry_out;
    logic       z_busy, z_clear_done;

    int n_cmp = 0;
    int n_err = 0;

    reg_file_param #(.WIDTH(4), .DEPTH(4), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut (
        .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_sel(wr_sel),
        .alu_data(alu_data), .load_data(load_data), .wr_addr(wr_addr),
        .rx_addr(rx_addr), .ry_addr(ry_addr), .clear_req(clear_req),
        .rx_out(rx_out), .ry_out(ry_out), .busy(busy), .clear_done(clear_done)
    );

    reg_file_param #(.WIDTH(4), .DEPTH(4), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_nb (
        .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_sel(wr_sel),
        .alu_data(alu_data), .load_data(load_data), .wr_addr(wr_addr),
        .rx_addr(rx_addr), .ry_addr(ry_addr), .clear_req(clear_req),
        .rx_out(nb_rx_out), .ry_out(nb_ry_out), .busy(nb_busy), .clear_done(nb_clear_done)
    );

    reg_file_param #(.WIDTH(4), .DEPTH(4), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_z (
        .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_sel(wr_sel),
        .alu_data(alu_data), .load_data(load_data), .wr_addr(wr_addr),
        .rx_addr(rx_addr), .ry_addr(ry_addr), .clear_req(clear_req),
        .rx_out(z_rx_out), .ry_out(z_ry_out), .busy(z_busy), .clear_done(z_clear_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_reg(input logic [1:0] addr, input logic [3:0] data);
        wr_en     = 1'b1;
        wr_sel    = 1'b1;
        wr_addr   = addr;
        load_data = data;
        tick();
        wr_en     = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < 4; a++) begin
            rx_addr = 2'(a);
            ry_addr = 2'(3 - a);
            tick();
            check_eq({tag, "_rx"}, 32'(rx_out), 32'h0);
            check_eq({tag, "_ry"}, 32'(ry_out), 32'h0);
        end
    endtask

    logic seen;

    initial begin
        reset_n   = 1'b0;
        wr_en     = 1'b0;
        wr_sel    = 1'b0;
        alu_data  = 4'h0;
        load_data = 4'h0;
        wr_addr   = 2'd0;
        rx_addr   = 2'd0;
        ry_addr   = 2'd0;
        clear_req = 1'b0;

        // Reset
        tick();
        tick();
        check_eq("rst_rx", 32'(rx_out), 32'h0);
        check_eq("rst_ry", 32'(ry_out), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_done", 32'(clear_done), 32'h0);
        reset_n = 1'b1;
        check_all_zero("post_rst");

        // Write source select
        wr_en = 1'b1; wr_addr = 2'd2; wr_sel = 1'b0; alu_data = 4'hA; load_data = 4'h0;
        tick();
        wr_addr = 2'd3; wr_sel = 1'b1; alu_data = 4'hF; load_data = 4'h5;
        tick();
        wr_en = 1'b0; rx_addr = 2'd2; ry_addr = 2'd3;
        tick();
        check_eq("sel_alu_r2", 32'(rx_out), 32'hA);
        check_eq("sel_load_r3", 32'(ry_out), 32'h5);

        // Bypass vs no bypass
        wr_en = 1'b1; wr_addr = 2'd1; wr_sel = 1'b0; alu_data = 4'h7;
        rx_addr = 2'd1; ry_addr = 2'd1;
        tick();
        check_eq("byp_rx", 32'(rx_out), 32'h7);
        check_eq("byp_ry", 32'(ry_out), 32'h7);
        check_eq("nobyp_old", 32'(nb_rx_out), 32'h0);
        wr_en = 1'b0;
        tick();
        check_eq("nobyp_new", 32'(nb_rx_out), 32'h7);

        // Hardwired zero register
        wr_en = 1'b1; wr_addr = 2'd0; wr_sel = 1'b0; alu_data = 4'hF; rx_addr = 2'd0;
        tick();
        check_eq("zero_wr_edge", 32'(z_rx_out), 32'h0);
        wr_en = 1'b0;
        tick();
        check_eq("zero_read", 32'(z_rx_out), 32'h0);
        check_eq("nonzero_r0", 32'(rx_out), 32'hF);

        // Bulk clear with blocked writes and an ignored re-request
        write_reg(2'd0, 4'h1);
        write_reg(2'd1, 4'h2);
        write_reg(2'd2, 4'h3);
        write_reg(2'd3, 4'h4);
        clear_req = 1'b1; rx_addr = 2'd3;
        tick();
        check_eq("clr_busy_0", 32'(busy), 32'h1);
        check_eq("clr_rd_0", 32'(rx_out), 32'h4);
        clear_req = 1'b0;
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'd1; alu_data = 4'h9;
        for (int k = 1; k < 4; k++) begin
            clear_req = (k == 2);
            tick();
            check_eq("clr_busy_k", 32'(busy), 32'h1);
            check_eq("clr_done_low", 32'(clear_done), 32'h0);
            check_eq("clr_rd_during", 32'(rx_out), 32'h4);
        end
        clear_req = 1'b0;
        tick();
        check_eq("clr_busy_end", 32'(busy), 32'h0);
        check_eq("clr_done_pulse", 32'(clear_done), 32'h1);
        check_eq("clr_byp_last", 32'(rx_out), 32'h0);
        check_eq("clr_nobyp_last", 32'(nb_rx_out), 32'h4);
        wr_en = 1'b0;
        tick();
        check_eq("clr_done_one", 32'(clear_done), 32'h0);
        check_eq("clr_idle_busy", 32'(busy), 32'h0);
        tick();
        check_eq("clr_no_retrig", 32'(busy), 32'h0);
        check_all_zero("after_clr");

        // Level-held request re-triggers after DONE
        clear_req = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check_eq("lvl_busy4", 32'(busy), 32'h1);
        tick();
        check_eq("lvl_done", 32'(clear_done), 32'h1);
        tick();
        check_eq("lvl_idle", 32'(busy), 32'h0);
        tick();
        check_eq("lvl_retrig", 32'(busy), 32'h1);
        clear_req = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            if (clear_done) seen = 1'b1;
        end
        check_eq("lvl_second_done", 32'(seen), 32'h1);
        tick();

        // Reset during a clear
        write_reg(2'd0, 4'h1);
        write_reg(2'd1, 4'h2);
        write_reg(2'd2, 4'h3);
        write_reg(2'd3, 4'h4);
        clear_req = 1'b1; rx_addr = 2'd3;
        tick();
        clear_req = 1'b0;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", 32'(busy), 32'h0);
        check_eq("mid_rst_done", 32'(clear_done), 32'h0);
        check_eq("mid_rst_rx", 32'(rx_out), 32'h0);
        tick();
        reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (clear_done || busy) seen = 1'b1;
        end
        check_eq("mid_rst_quiet", 32'(seen), 32'h0);
        check_all_zero("mid_rst_regs");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
